// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package seg7_scan_ctrl_pkg;

    // Scan FSM: all anodes off (anti-ghost) or one anode driven.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // One display word as captured by the load handshake.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
    } disp_word_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g, indexed by nibble.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    // True when digit n (n >= 1) and every digit above it are zero.
    function automatic logic lead_zero(input logic [15:0] value, input logic [1:0] n);
        logic [15:0] upper;
        upper = value >> {n, 2'b00};
        return (n != 2'd0) && (upper == 16'h0000);
    endfunction

endpackage

// File: rtl/seg7_nibble_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_nibble_dec
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; the pattern table lives in the package.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a one-deep
// pending buffer that is committed to the display only at frame boundaries.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_value,
    input  logic [3:0]  load_dp,
    input  logic        load_lzb,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    disp_word_t       act_q, act_d;
    disp_word_t       pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;

    logic             boundary;
    logic             accept;
    logic [3:0]       nibble;
    logic [6:0]       seg_pat;
    logic             digit_blank;

    seg7_nibble_dec u_dec (
        .nibble (nibble),
        .seg    (seg_pat)
    );

    // Scan FSM next state: shared counter restarts on every state change.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d  = ST_BLANK;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake and frame commit; a word accepted on the boundary waits a frame.
    always_comb begin
        load_ready  = ~pend_full_q | ~rst_n;
        accept      = load_valid & ~pend_full_q;
        frame_tick  = boundary & rst_n;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (boundary) begin
            if (pend_full_q) begin
                act_d = pend_q;
            end
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = '{value: load_value, dp: load_dp, lzb: load_lzb};
            pend_full_d = 1'b1;
        end
    end

    // Pin values for the current state; registered below for one cycle latency.
    always_comb begin
        nibble      = act_q.value[{idx_q, 2'b00} +: 4];
        digit_blank = act_q.lzb & lead_zero(act_q.value, idx_q);
        an_d        = AN_OFF;
        sseg_d      = SEG_OFF;
        if (state_q == ST_DRIVE && !digit_blank) begin
            an_d   = ~(4'b0001 << idx_q);
            sseg_d = {~act_q.dp[idx_q], seg_pat};
        end
    end

    // State, buffers and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            an_q        <= AN_OFF;
            sseg_q      <= SEG_OFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule
